// File: rtl/memory_stage.sv
// MEM stage: word-addressed data memory, beq resolution and the MEM/WB register.
// A post-reset clear pass zeroes the memory while holding ready low.
module memory_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeData,
    input  logic [4:0]  inWr,
    input  logic        zero,
    input  logic [9:0]  inPC,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        branch,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    output logic        ready,
    output logic        pcSrc,
    output logic [9:0]  branchPC,
    output logic [31:0] readData,
    output logic [31:0] outAluResult,
    output logic [4:0]  outWr,
    output logic        outRegWrite,
    output logic        outMemToReg,
    output logic        misaligned
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [31:0]       r_mem [DEPTH];

    logic              w_run;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mis;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;
    logic              w_unused;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign w_unused = &{1'b0, aluResult[31:ADDR_W+2]};

    assign w_idx = aluResult[ADDR_W+1:2];
    assign w_mis = (aluResult[1:0] != 2'b00) && (memRead || memWrite);

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == CLEAR && r_cnt == ADDR_W'(DEPTH - 1)) begin
            w_next = RUN;
        end
    end

    always_comb begin
        w_run = (r_state == RUN);
        ready = w_run;
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_idx;
        w_wdata = writeData;
        if (!w_run) begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = '0;
        end else if (memWrite && !w_mis) begin
            w_we = 1'b1;
        end
    end

    always_ff @(negedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // MEM/WB register; carries a bubble for the whole clear pass.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            pcSrc        <= 1'b0;
            branchPC     <= '0;
            readData     <= '0;
            outAluResult <= '0;
            outWr        <= '0;
            outRegWrite  <= 1'b0;
            outMemToReg  <= 1'b0;
        end else if (!w_run) begin
            pcSrc        <= 1'b0;
            branchPC     <= '0;
            readData     <= '0;
            outAluResult <= '0;
            outWr        <= '0;
            outRegWrite  <= 1'b0;
            outMemToReg  <= 1'b0;
        end else begin
            pcSrc        <= branch & zero;
            if (branch) begin
                branchPC <= inPC;
            end
            readData     <= (memRead && !w_mis) ? r_mem[w_idx] : '0;
            outAluResult <= aluResult;
            outWr        <= inWr;
            outRegWrite  <= inRegWrite & ~w_mis;
            outMemToReg  <= inMemToReg;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else if (w_run && w_mis) begin
            misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: clear timing, load/store, pass-through,
// branch resolution, misalignment and reset behaviour.
module tb_memory_stage;

    logic        clock;
    logic        reset;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [4:0]  inWr;
    logic        zero;
    logic [9:0]  inPC;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        inRegWrite;
    logic        inMemToReg;
    logic        ready;
    logic        pcSrc;
    logic [9:0]  branchPC;
    logic [31:0] readData;
    logic [31:0] outAluResult;
    logic [4:0]  outWr;
    logic        outRegWrite;
    logic        outMemToReg;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    int n;

    memory_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clock(clock),
        .reset(reset),
        .aluResult(aluResult),
        .writeData(writeData),
        .inWr(inWr),
        .zero(zero),
        .inPC(inPC),
        .memRead(memRead),
        .memWrite(memWrite),
        .branch(branch),
        .inRegWrite(inRegWrite),
        .inMemToReg(inMemToReg),
        .ready(ready),
        .pcSrc(pcSrc),
        .branchPC(branchPC),
        .readData(readData),
        .outAluResult(outAluResult),
        .outWr(outWr),
        .outRegWrite(outRegWrite),
        .outMemToReg(outMemToReg),
        .misaligned(misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, let one falling edge sample it, settle.
    task automatic op(input logic [31:0] a, input logic [31:0] d,
                      input logic rd, input logic wr_, input logic [4:0] w,
                      input logic rw, input logic m2r, input logic br,
                      input logic z, input logic [9:0] pc);
        aluResult  = a;
        writeData  = d;
        memRead    = rd;
        memWrite   = wr_;
        inWr       = w;
        inRegWrite = rw;
        inMemToReg = m2r;
        branch     = br;
        zero       = z;
        inPC       = pc;
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        op(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk(tag, n, 32'd256);
    endtask

    initial begin
        aluResult  = '0;
        writeData  = '0;
        inWr       = '0;
        zero       = 1'b0;
        inPC       = '0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        branch     = 1'b0;
        inRegWrite = 1'b0;
        inMemToReg = 1'b0;
        reset      = 1'b0;

        #15;
        chk("rst_ready", ready, 32'd0);
        chk("rst_alu", outAluResult, 32'd0);
        chk("rst_mis", misaligned, 32'd0);
        #5;
        @(posedge clock);
        reset = 1'b1;
        chk("clr_ready0", ready, 32'd0);
        wait_ready("clear_edges");

        op(32'h3FC, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("ld_3fc", readData, 32'd0);
        chk("ld_m2r", outMemToReg, 32'd1);

        op(32'd16, 32'hDEADBEEF, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        chk("st_rd0", readData, 32'd0);
        op(32'd16, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("ld_16", readData, 32'hDEADBEEF);
        op(32'd1040, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("ld_wrap", readData, 32'hDEADBEEF);
        chk("mis_clean", misaligned, 32'd0);

        op(32'd11, 32'h77, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk("r_alu", outAluResult, 32'd11);
        chk("r_wr", outWr, 32'd2);
        chk("r_rw", outRegWrite, 32'd1);
        chk("r_rd", readData, 32'd0);
        chk("r_m2r", outMemToReg, 32'd0);

        op(32'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd514);
        chk("beq_t_src", pcSrc, 32'd1);
        chk("beq_t_pc", branchPC, 32'd514);
        op(32'd1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd600);
        chk("beq_nt_src", pcSrc, 32'd0);
        chk("beq_nt_pc", branchPC, 32'd600);
        op(32'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd77);
        chk("nobr_src", pcSrc, 32'd0);
        chk("nobr_pc", branchPC, 32'd600);

        op(32'd18, 32'h55, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk("mis_set", misaligned, 32'd1);
        chk("mis_rw", outRegWrite, 32'd0);
        op(32'd16, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("mis_nowr", readData, 32'hDEADBEEF);
        chk("mis_ok_rw", outRegWrite, 32'd1);
        op(32'd17, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("mis_ld_rd", readData, 32'd0);
        chk("mis_ld_rw", outRegWrite, 32'd0);
        op(32'd20, 32'h9, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk("mis_sticky", misaligned, 32'd1);

        op(32'd16, 32'hCAFEF00D, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("rw_old", readData, 32'hDEADBEEF);
        op(32'd16, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("rw_new", readData, 32'hCAFEF00D);

        op(32'd8, 32'h1234, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        op(32'd8, 32'h0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd33);
        chk("ld_8", readData, 32'h1234);
        chk("pre_rst_alu", outAluResult, 32'd8);

        reset = 1'b0;
        #1;
        chk("arst_alu", outAluResult, 32'd0);
        chk("arst_rd", readData, 32'd0);
        chk("arst_pc", branchPC, 32'd0);
        chk("arst_src", pcSrc, 32'd0);
        chk("arst_rw", outRegWrite, 32'd0);
        chk("arst_mis", misaligned, 32'd0);
        chk("arst_ready", ready, 32'd0);
        @(posedge clock);
        reset = 1'b1;
        idle();
        repeat (99) @(negedge clock);
        #1;
        chk("mid_clr_ready", ready, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 32'd0);
        chk("mid_rst_alu", outAluResult, 32'd0);
        @(posedge clock);
        reset = 1'b1;
        wait_ready("reclear_edges");

        op(32'd8, 32'h0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("ld_8_clr", readData, 32'd0);
        chk("mis_after", misaligned, 32'd0);
        chk("rw_after", outRegWrite, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the Execute stage.
- Consumes aluResult, outData2, wr, zero and outPC from Execute, plus control bits forwarded from Decode.
- Owns the word-addressed data memory, resolves beq (pcSrc/branchPC back to Fetch) and holds the MEM/WB pipeline register.
- After reset, runs a sequential memory-clear sequence and stalls the pipeline via ready until the clear completes.

Parameters:
DEPTH, 256, number of 32-bit data-memory words (power of 2)
ADDR_W, 8, log2(DEPTH); word-index width

Ports:
clock  input  1  pipeline clock; all state updates on falling edge, same as Execute
reset  input  1  asynchronous, active-low reset
aluResult  input  32  byte address for load/store; pass-through value for R-type
writeData  input  32  store data (Execute outData2)
inWr  input  5  destination register from Execute
zero  input  1  ALU zero flag
inPC  input  10  branch target from Execute outPC
memRead  input  1  load
memWrite  input  1  store
branch  input  1  beq
inRegWrite  input  1  WB register-write enable
inMemToReg  input  1  WB select: 1 = readData, 0 = aluResult
ready  output  1  0 during clear; upstream must stall while low
pcSrc  output  1  take branch
branchPC  output  10  registered branch target
readData  output  32  registered load data
outAluResult  output  32  registered aluResult
outWr  output  5  registered destination register
outRegWrite  output  1  registered, qualified regWrite
outMemToReg  output  1  registered memToReg
misaligned  output  1  sticky alignment-error flag

Behaviour:
Reset (reset=0, asynchronous):
- All outputs go to 0 immediately.
- FSM enters CLEAR; clear counter resets to 0.
- Memory contents are not guaranteed until CLEAR finishes.

FSM, falling-edge, states CLEAR and RUN:
- CLEAR: each edge writes 0 to mem[counter] and increments counter. At counter==DEPTH-1, writes that word, then moves to RUN. CLEAR lasts exactly DEPTH edges.
- CLEAR: ready=0; all inputs ignored; MEM/WB register holds a bubble (outRegWrite=0, pcSrc=0, other outputs 0).
- RUN: ready=1 from the edge that enters RUN. RUN is left only by reset.
- Reset asserted mid-CLEAR or mid-RUN: returns to CLEAR with counter=0 and restarts the full clear.

Addressing:
- Word index = aluResult[ADDR_W+1:2].
- Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- aluResult[1:0]!=0 with memRead or memWrite set is misaligned:
  - no memory write;
  - readData=0;
  - outRegWrite forced to 0 for that instruction;
  - misaligned set to 1 and held until reset.

RUN, each falling edge (inputs sampled at edge N, outputs valid from edge N until edge N+1):
- memWrite=1, aligned: mem[idx] <= writeData.
- memRead=1, aligned: readData <= mem[idx], giving the value before any write on the same edge. Otherwise readData <= 0.
- memRead and memWrite both 1: the write is performed; readData returns the old contents.
- A store at edge N is visible to a load at edge N+1. No forwarding is needed.
- outAluResult <= aluResult; outWr <= inWr; outMemToReg <= inMemToReg.
- outRegWrite <= inRegWrite, except when misaligned as above.
- pcSrc <= branch & zero.
- branchPC <= inPC when branch=1, else holds its previous value.
- Load latency: 1 falling edge, address to readData.

Test Plan:
1. Reset low 20ns, release -> ready=0 for exactly 256 falling edges, then 1. Load from addr 0x3FC during RUN returns 0.
2. Store: aluResult=16, writeData=0xDEADBEEF, memWrite=1; next edge load aluResult=16 -> readData=0xDEADBEEF. Load aluResult=16+1024 (wrap) -> same value.
3. R-type pass-through: aluResult=11, inWr=2, inRegWrite=1, inMemToReg=0 -> after one edge outAluResult=11, outWr=2, outRegWrite=1, readData=0.
4. beq: branch=1, zero=1, inPC=514 -> pcSrc=1, branchPC=514. Then branch=1, zero=0, inPC=600 -> pcSrc=0, branchPC=600. Then branch=0 -> branchPC stays 600.
5. Misaligned: store aluResult=18, memWrite=1, inRegWrite=1 -> misaligned=1, outRegWrite=0, mem[4] unchanged (load 16 returns prior value). Flag stays 1 across later valid ops until reset.
6. Reset mid-operation: store 0x1234 at addr 8, assert reset at CLEAR counter=100 in a later clear cycle -> outputs 0 at once. After a full 256-edge clear, load addr 8 -> 0. Also check readData=old value when memRead and memWrite both set.
